hilo_div_unit: RTL and testbench

Iterative 32-bit radix-2 divider that responds to the EX-stage ALU's multi-cycle request handshake. It implements MIPS DIV and DIVU: it takes operands when started, holds the EX stage via `stall` while iterating, pulses `done` when finished, and presents `{remainder, quotient}` as the 64-bit HI/LO write data. It sits beside the ALU inside the execute stage and feeds the HI/LO write path.

---
 rtl/mdu_pkg.sv | 15 +
 rtl/div_step.sv | 25 ++
 rtl/hilo_div_unit.sv | 137 +++++++++++++
 tb/tb_hilo_div_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// HI/LO packing: hilo = {HI, LO} = {remainder, quotient}.
package mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_t;

  localparam int          DIV_ITERS  = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring divide iteration: shift {rem,quo} left by one, then
// conditionally subtract the divisor magnitude and set the new quotient bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);

  logic [W+1:0] sh;
  logic [W:0]   diff;
  logic         ge;

  always_comb begin
    sh    = {rem_i, quo_i[W-1]};
    ge    = (sh >= {2'b00, dvs_i});
    diff  = sh[W:0] - {1'b0, dvs_i};
    rem_o = ge ? diff : sh[W:0];
    quo_o = {quo_i[W-2:0], ge};
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative radix-2 DIV/DIVU for the EX stage; result {remainder, quotient} to HI/LO.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module hilo_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = DIV_ITERS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]   divisor,
  input  logic                flush,
  input  logic                hold,
  output logic                stall,
  output logic                done,
  output logic [2*DATA_W-1:0] hilo
);

  localparam int CW = $clog2(DATA_W);

  div_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_W:0]       r_q, r_d;
  logic [DATA_W-1:0]     q_q, q_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [2*DATA_W-1:0]   hilo_q, hilo_d;

  logic [DATA_W:0]       step_rem;
  logic [DATA_W-1:0]     step_quo;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W-1:0]     q_fix, r_fix;
  logic                  a_neg, b_neg;

  div_step #(.W(DATA_W)) u_step (
    .rem_i (r_q),
    .quo_i (q_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hilo_d  = hilo_q;

    a_neg = is_signed & dividend[DATA_W-1];
    b_neg = is_signed & divisor[DATA_W-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
    q_fix = q_neg_q ? -q_q : q_q;
    r_fix = r_neg_q ? -r_q[DATA_W-1:0] : r_q[DATA_W-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            hilo_d  = {dividend, {DATA_W{1'b1}}};
            state_d = S_DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            hilo_d  = {dividend, {DATA_W{1'b0}}};
            state_d = S_DONE;
          end
`endif
          else begin
            r_d     = '0;
            q_d     = a_mag;
            dvs_d   = b_mag;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        r_d   = step_rem;
        q_d   = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hilo_d  = {r_fix, q_fix};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush abandons the operation without touching the architectural result.
    if (flush) begin
      state_d = S_IDLE;
      hilo_d  = hilo_q;
    end

    stall = ((state_q == S_IDLE) & start & ~flush) |
            (state_q == S_CALC) | (state_q == S_FIX);
    done  = (state_q == S_DONE);
    hilo  = hilo_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hilo_q  <= hilo_d;
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: reference results from native division,
// queued at request time and compared when done rises.
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        stall, done;
  logic [63:0] hilo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_hilo = '0;

  hilo_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush), .hold(hold),
    .stall(stall), .done(done), .hilo(hilo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] am, bm;
    am = (s && a[31]) ? -a : a;
    bm = (s && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (am < bm) return 1;
`endif
    if (am == bm) return 34;
    return 34;
  endfunction

  // Issue a request now, wait for done, check latency/stall/result, step to IDLE.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    int lat, stalls, el;
    logic [63:0] exp;
    sb_q.push_back(model(s, a, b));
    el = exp_lat(s, a, b);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    lat = 0; stalls = 0;
    #1;
    while (!done && lat < 100) begin
      if (stall) stalls++;
      tick();
      start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(el));
    check({tag, "_stalls"}, 64'(stalls), 64'(el));
    check({tag, "_stall_at_done"}, 64'(stall), 64'd0);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "_hilo"}, hilo, exp);
      last_hilo = exp;
    end
    tick();
  endtask

  initial begin
    int seen;
    logic [63:0] exp;

    #2;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", hilo, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    check("divu_100_7_lit", hilo, {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_lit", hilo, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1_lit", hilo, {32'd0, 32'h8000_0000});
    run_div("divu_by0", 1'b0, 32'h0000_1234, 32'd0);
    check("divu_by0_lit", hilo, {32'h0000_1234, 32'hFFFF_FFFF});
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_div("div_m100_m9", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF7);
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 4; i++)
      run_div("rand", 1'(i), $urandom, $urandom_range(1, 32'h0001_0000));

    // Flush in cycle 10 of a divide.
    start = 1'b1; is_signed = 1'b0; dividend = 32'h0000_FFFF; divisor = 32'd3;
    for (int c = 0; c < 10; c++) begin
      tick();
      start = 1'b0;
    end
    check("flush_c10_stall", 64'(stall), 64'd1);
    flush = 1'b1; start = 1'b1; divisor = 32'd0;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_c11_stall", 64'(stall), 64'd0);
    check("flush_c11_done", 64'(done), 64'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) seen++;
      tick();
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hilo_kept", hilo, last_hilo);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3);
    check("divu_9_3_lit", hilo, {32'd0, 32'd3});

    // Hold at DONE for 3 cycles with a start that must be ignored.
    sb_q.push_back(model(1'b0, 32'd1000, 32'd10));
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    seen = 0;
    #1;
    while (!done && seen < 100) begin
      tick();
      start = 1'b0;
      seen++;
    end
    check("hold_lat", 64'(seen), 64'(exp_lat(1'b0, 32'd1000, 32'd10)));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
    start = 1'b1; dividend = 32'd7; divisor = 32'd0;
    for (int k = 0; k < 4; k++) begin
      hold = (k < 3);
      #1;
      check($sformatf("hold_done_%0d", k), 64'(done), 64'd1);
      check($sformatf("hold_hilo_%0d", k), hilo, exp);
      tick();
    end
    start = 1'b0; hold = 1'b0;
    #1;
    check("hold_after_done", 64'(done), 64'd0);
    check("hold_after_stall", 64'(stall), 64'd0);
    check("hold_after_hilo", hilo, exp);
    tick();

    // Reset asserted in cycle 20.
    start = 1'b1; is_signed = 1'b0; dividend = 32'h0000_DEAD; divisor = 32'h11;
    for (int c = 0; c < 20; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("rst_mid_stall", 64'(stall), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hilo", hilo, 64'd0);
    tick();
    tick();
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) seen++;
      tick();
    end
    check("rst_no_done", 64'(seen), 64'd0);

    run_div("divu_5_9", 1'b0, 32'd5, 32'd9);
    check("divu_5_9_lit", hilo, {32'd5, 32'd0});
    run_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
